// File: rtl/harness_pkg.sv
// Shared widths and helpers for the dual-core lockstep harness.
package harness_pkg;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 32;

   // Counters stop at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (value == {CNT_W{1'b1}}) begin
         result = value;
      end else begin
         result = value + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return result;
   endfunction

endpackage

// File: rtl/lockstep_clk_gate.sv
// Glitch-free clock gate: enable is sampled while clk is low, then ANDed with clk.
module lockstep_clk_gate (
   input  logic clk,
   input  logic rst_n,
   input  logic gate_n,
   output logic clk_gated,
   output logic gate_reg
);

   logic gate_r;

   // Gate enable captured on the falling edge so it never changes while clk is high.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_r <= 1'b1;
      end else begin
         gate_r <= gate_n;
      end
   end

   assign clk_gated = clk & gate_r;
   assign gate_reg  = gate_r;

endmodule

// File: rtl/dual_core_lockstep_ctrl.sv
// Lockstep controller: per-core gated clocks, fetch-end enables, drain/timeout finish
// detection and a sticky timing-equivalence flag.
module dual_core_lockstep_ctrl
   import harness_pkg::*;
#(
   parameter logic [ADDR_W-1:0] END_ADDR       = 32'h0000_0100,
   parameter logic [CNT_W-1:0]  DRAIN_CYCLES   = 32'd16,
   parameter logic [CNT_W-1:0]  TIMEOUT_CYCLES = 32'd4096
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              retire_1_i,
   input  logic              retire_2_i,
   input  logic              fetch_1_i,
   input  logic              fetch_2_i,
   input  logic [ADDR_W-1:0] instr_addr_1_i,
   input  logic [ADDR_W-1:0] instr_addr_2_i,
   output logic              clk_1_o,
   output logic              clk_2_o,
   output logic              retire_o,
   output logic              enable_1_o,
   output logic              enable_2_o,
   output logic              finished_o,
   output logic              atk_equiv_o
);

   logic             gate_1_s, gate_2_s;
   logic             gate_reg_1_s, gate_reg_2_s;
   logic             enable_1_r, enable_2_r, enable_1_s, enable_2_s;
   logic             finished_r, finished_s;
   logic             equiv_r, equiv_s;
   logic [CNT_W-1:0] drain_r, drain_s;
   logic [CNT_W-1:0] cycle_r, cycle_s;

   // A core that retired ahead of its partner is frozen until the partner retires too.
   assign gate_1_s = ~(retire_1_i & ~retire_2_i);
   assign gate_2_s = ~(retire_2_i & ~retire_1_i);
   assign retire_o = retire_1_i & retire_2_i;

   lockstep_clk_gate u_gate_1 (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .gate_n    (gate_1_s),
      .clk_gated (clk_1_o),
      .gate_reg  (gate_reg_1_s)
   );

   lockstep_clk_gate u_gate_2 (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .gate_n    (gate_2_s),
      .clk_gated (clk_2_o),
      .gate_reg  (gate_reg_2_s)
   );

   // Next-state for enables, drain/cycle counters, finish and equivalence.
   always_comb begin
      enable_1_s = enable_1_r;
      enable_2_s = enable_2_r;
      drain_s    = {CNT_W{1'b0}};
      equiv_s    = equiv_r;

      if (fetch_1_i && (instr_addr_1_i >= END_ADDR)) begin
         enable_1_s = 1'b0;
      end else begin
         enable_1_s = enable_1_r;
      end

      if (fetch_2_i && (instr_addr_2_i >= END_ADDR)) begin
         enable_2_s = 1'b0;
      end else begin
         enable_2_s = enable_2_r;
      end

      if (retire_1_i || retire_2_i) begin
         drain_s = {CNT_W{1'b0}};
      end else if (!enable_1_r && !enable_2_r) begin
         drain_s = sat_inc(drain_r);
      end else begin
         drain_s = {CNT_W{1'b0}};
      end

      cycle_s    = sat_inc(cycle_r);
      finished_s = finished_r || (drain_s >= DRAIN_CYCLES) || (cycle_s >= TIMEOUT_CYCLES);

      // The flag only observes the run; once finished it is frozen.
      if (!finished_r && (gate_reg_1_s != gate_reg_2_s)) begin
         equiv_s = 1'b0;
      end else begin
         equiv_s = equiv_r;
      end
   end

   // Run-control and equivalence state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         enable_1_r <= 1'b1;
         enable_2_r <= 1'b1;
         drain_r    <= {CNT_W{1'b0}};
         cycle_r    <= {CNT_W{1'b0}};
         finished_r <= 1'b0;
         equiv_r    <= 1'b1;
      end else begin
         enable_1_r <= enable_1_s;
         enable_2_r <= enable_2_s;
         drain_r    <= drain_s;
         cycle_r    <= cycle_s;
         finished_r <= finished_s;
         equiv_r    <= equiv_s;
      end
   end

   assign enable_1_o  = enable_1_r;
   assign enable_2_o  = enable_2_r;
   assign finished_o  = finished_r;
   assign atk_equiv_o = equiv_r;

endmodule

// File: tb/tb_dual_core_lockstep_ctrl.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a monitor compares them.
module tb_dual_core_lockstep_ctrl;

   logic        clk_i;
   logic        rst_ni;
   logic        retire_1_i, retire_2_i, fetch_1_i, fetch_2_i;
   logic [31:0] instr_addr_1_i, instr_addr_2_i;
   logic        clk_1_o, clk_2_o, retire_o, enable_1_o, enable_2_o, finished_o, atk_equiv_o;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   int          q_cyc[$];
   logic [6:0]  q_exp[$];
   string       q_name[$];

   dual_core_lockstep_ctrl #(
      .END_ADDR       (32'h0000_0100),
      .DRAIN_CYCLES   (32'd16),
      .TIMEOUT_CYCLES (32'd64)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .retire_1_i     (retire_1_i),
      .retire_2_i     (retire_2_i),
      .fetch_1_i      (fetch_1_i),
      .fetch_2_i      (fetch_2_i),
      .instr_addr_1_i (instr_addr_1_i),
      .instr_addr_2_i (instr_addr_2_i),
      .clk_1_o        (clk_1_o),
      .clk_2_o        (clk_2_o),
      .retire_o       (retire_o),
      .enable_1_o     (enable_1_o),
      .enable_2_o     (enable_2_o),
      .finished_o     (finished_o),
      .atk_equiv_o    (atk_equiv_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Expected vector order: {clk_1, clk_2, retire, enable_1, enable_2, finished, atk_equiv}
   function automatic logic [6:0] v(input logic c1, c2, rt, e1, e2, fn, eq);
      return {c1, c2, rt, e1, e2, fn, eq};
   endfunction

   // Monitor: samples in the high phase of clk_i, where a gated clock equals its gate.
   always @(posedge clk_i) begin
      logic [6:0] obs;
      #1;
      obs = {clk_1_o, clk_2_o, retire_o, enable_1_o, enable_2_o, finished_o, atk_equiv_o};
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
         n_checks = n_checks + 1;
         if (q_cyc[0] < cyc) begin
            $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", q_name[0], q_cyc[0], cyc);
         end else if (obs !== q_exp[0]) begin
            $display("FAIL %s cyc=%0d got=%b expected=%b (c1 c2 rt e1 e2 fin eq)",
                     q_name[0], cyc, obs, q_exp[0]);
         end else begin
            n_pass = n_pass + 1;
         end
         void'(q_cyc.pop_front());
         void'(q_exp.pop_front());
         void'(q_name.pop_front());
      end
   end

   task automatic step(input string nm, input logic r1, r2, f1, f2,
                       input logic [31:0] a1, a2, input logic [6:0] exp);
      retire_1_i     = r1;
      retire_2_i     = r2;
      fetch_1_i      = f1;
      fetch_2_i      = f2;
      instr_addr_1_i = a1;
      instr_addr_2_i = a2;
      q_cyc.push_back(cyc + 1);
      q_exp.push_back(exp);
      q_name.push_back(nm);
      @(posedge clk_i);
      #2;
   endtask

   task automatic do_reset();
      rst_ni         = 1'b0;
      retire_1_i     = 1'b0;
      retire_2_i     = 1'b0;
      fetch_1_i      = 1'b0;
      fetch_2_i      = 1'b0;
      instr_addr_1_i = 32'h0;
      instr_addr_2_i = 32'h0;
      q_cyc.push_back(cyc + 1);
      q_exp.push_back(v(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
      q_name.push_back("reset");
      @(posedge clk_i);
      #2;
      rst_ni = 1'b1;
   endtask

   initial begin
      rst_ni         = 1'b0;
      retire_1_i     = 1'b0;
      retire_2_i     = 1'b0;
      fetch_1_i      = 1'b0;
      fetch_2_i      = 1'b0;
      instr_addr_1_i = 32'h0;
      instr_addr_2_i = 32'h0;
      @(posedge clk_i);
      #2;

      do_reset();
      for (int i = 0; i < 4; i++)
         step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, v(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));

      // Core 1 runs ahead for three cycles, then core 2 catches up.
      for (int i = 0; i < 3; i++)
         step("stall1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, v(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      step("catchup", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, v(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
      step("post_catchup", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, v(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));

      // Reset mid-run restores the equivalence flag; then simultaneous retires.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         logic rt;
         rt = (i % 2 == 0) ? 1'b1 : 1'b0;
         step("simul", rt, rt, 1'b0, 1'b0, 32'h0, 32'h0, v(1'b1, 1'b1, rt, 1'b1, 1'b1, 1'b0, 1'b1));
      end

      // Fetch-end enables, then drain with a restart by a retire on the 10th drain edge.
      do_reset();
      step("addr_ff",    1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00FF, 32'h0, v(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
      step("addr_100",   1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, v(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      step("addr_drop",  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, v(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      step("no_fetch2",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0200, v(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      step("en2_clear",  1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_1000, v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      for (int j = 1; j <= 27; j++) begin
         logic rt;
         logic fn;
         rt = (j == 10) ? 1'b1 : 1'b0;
         fn = (j >= 26) ? 1'b1 : 1'b0;
         step("drain", rt, rt, 1'b0, 1'b0, 32'h0, 32'h0, v(1'b1, 1'b1, rt, 1'b0, 1'b0, fn, 1'b1));
      end

      // Timeout at the 64th edge after reset, then mismatched gates leave the flag alone.
      do_reset();
      for (int j = 1; j <= 66; j++) begin
         if (j <= 64) begin
            logic fn;
            fn = (j >= 64) ? 1'b1 : 1'b0;
            step("timeout", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, v(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, fn, 1'b1));
         end else begin
            step("frozen", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, v(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
         end
      end

      retire_1_i = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #3;
      if (q_cyc.size() != 0) begin
         n_checks = n_checks + 1;
         $display("FAIL drain_queue: %0d expected entries never compared, required 0", q_cyc.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dual_core_lockstep_ctrl.md
Name: dual_core_lockstep_ctrl

Overview:
- Verification-harness controller that runs two copies of the same core in lockstep at the granularity of retired instructions.
- Derives one gated clock per core from a single harness clock.
- Stalls whichever core retires first until the other core catches up, and gates fetch at the program end.
- Raises finished and maintains a sticky attacker-equivalence flag that compares the two cores' timing, i.e. their clock-enable patterns.

Parameters:
- END_ADDR, 32'h0000_0100, first instruction address outside the program; fetching at or beyond it disables that core.
- DRAIN_CYCLES, 16, cycles with both cores disabled and no retire before finished asserts.
- TIMEOUT_CYCLES, 4096, cycle count after reset at which finished is forced.

Ports:
- clk_i  in  1  harness clock
- rst_ni  in  1  asynchronous active-low reset
- retire_1_i  in  1  core 1 retire strobe (RVFI valid, level held while its clock is stopped)
- retire_2_i  in  1  core 2 retire strobe
- fetch_1_i  in  1  core 1 fetch active
- fetch_2_i  in  1  core 2 fetch active
- instr_addr_1_i  in  32  core 1 instruction fetch address
- instr_addr_2_i  in  32  core 2 instruction fetch address
- clk_1_o  out  1  gated clock, core 1
- clk_2_o  out  1  gated clock, core 2
- retire_o  out  1  both cores retiring together
- enable_1_o  out  1  fetch enable, core 1
- enable_2_o  out  1  fetch enable, core 2
- finished_o  out  1  run complete
- atk_equiv_o  out  1  timing observations identical so far (sticky)

Behaviour:
- Clock gating:
  - gate_n = NOT(retire_n_i AND NOT retire_other_i). A core that has retired while the other has not is frozen.
  - gate_n is captured in a register on the falling edge of clk_i.
  - clk_n_o = clk_i AND gate_reg_n, so the output clock is glitch-free.
  - On reset, gate_reg_1 = gate_reg_2 = 1, so both clocks free-run.
- retire_o = retire_1_i AND retire_2_i (combinational). When it is high, both gates are open, so both cores advance together on the next edge.
- Simultaneous retire: both gates stay open and retire_o = 1 for that cycle.
- Neither core retiring: both gates stay open.
- Enables:
  - enable_n_o resets to 1.
  - It clears and stays cleared when fetch_n_i = 1 and instr_addr_n_i >= END_ADDR (unsigned compare) at a rising clk_i edge.
  - It is never re-set without reset.
- finished_o:
  - Resets to 0; sticky once set.
  - A drain counter counts cycles with enable_1_o = enable_2_o = 0 and retire_1_i = retire_2_i = 0. The counter clears on any retire.
  - finished_o sets when the drain counter reaches DRAIN_CYCLES, or when the free-running cycle counter reaches TIMEOUT_CYCLES.
  - The cycle counter saturates and does not wrap.
- atk_equiv_o:
  - Resets to 1.
  - At each rising clk_i edge while finished_o = 0, if gate_reg_1 != gate_reg_2 then atk_equiv_o <= 0, sticky.
  - After finished_o it is frozen.
- Reset mid-run: all registers return asynchronously to their reset values, and clocks resume immediately.
- All counters are 32-bit unsigned.

Decomposition:
- Shared package (harness_pkg): address width 32 and the counter width constant.
- Three internal sub-blocks inside the top:
  - clock-gate unit: negedge gate register plus AND.
  - run controller: enables, drain counter, timeout counter, finished.
  - equivalence monitor: sticky compare.
- One natural sub-module: lockstep_clk_gate, instantiated twice.

Test Plan:
- Reset with all inputs 0 → clk_1_o/clk_2_o toggle with clk_i; enables = 1; finished_o = 0; atk_equiv_o = 1.
- retire_1_i = 1 for 3 cycles while retire_2_i = 0, then retire_2_i = 1:
  - clk_1_o is held low for those 3 cycles.
  - retire_o = 1 in the cycle both are high.
  - atk_equiv_o falls to 0.
- retire_1_i = retire_2_i = 1 together every 2nd cycle → both clocks never gated; retire_o pulses match; atk_equiv_o stays 1.
- instr_addr_1_i = 32'h100 with fetch_1_i = 1 → enable_1_o = 0 next edge and stays 0 when the address drops to 32'h0; enable_2_o is unaffected.
- Both enables cleared, no retire for 16 cycles → finished_o = 1 on the 16th edge. A retire at cycle 10 restarts the count.
- Never disable, TIMEOUT_CYCLES = 64 → finished_o = 1 at cycle 64; after that, forced gate mismatches leave atk_equiv_o unchanged.
